haraka_core: RTL

- Parametrised, handshaked, iterative Haraka v2 permutation core supporting Haraka-512 and Haraka-256, selected per job.
- One quad-lane AES step per cycle; the Mix step is fused into every second AES step.
- Applies the feed-forward XOR and Haraka-512 truncation internally and delivers a 256-bit digest over a valid/ready interface.
- Sits between the hash-tree scheduler (input side) and the digest collector (output side).

---
 rtl/haraka_core.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/haraka_core.sv
// Iterative Haraka v2 core (Haraka-512 / Haraka-256 selected per job): one quad-lane AES step
// per cycle, Mix fused into every odd step, feed-forward and truncation applied on completion.
module haraka_core #(
  parameter  int unsigned ROUNDS   = 5,
  localparam int unsigned RC_SLOTS = 8 * ROUNDS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [511:0]            in_data,
  input  logic [128*RC_SLOTS-1:0] rc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [255:0]            out_data,
  output logic                    busy
);

  localparam int unsigned Steps = 2 * ROUNDS;
  localparam int unsigned StepW = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(Steps - 1);

  // Source word for each output word of the Mix, packed low to high
  localparam logic [63:0] Mix512Map = {4'd14, 4'd6, 4'd10, 4'd2, 4'd5, 4'd13, 4'd1, 4'd9,
                                       4'd4, 4'd12, 4'd0, 4'd8, 4'd15, 4'd7, 4'd11, 4'd3};
  localparam logic [23:0] Mix256Map = {3'd7, 3'd3, 3'd6, 3'd2, 3'd5, 3'd1, 3'd4, 3'd0};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), followed by the AES affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_step(input logic [127:0] st, input logic [127:0] key);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int b = 0; b < 16; b++) sb[b] = sbox(st[8*b +: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      o[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o ^ key;
  endfunction

  state_e             r_state;
  logic [StepW-1:0]   r_step;
  logic               r_mode;
  logic [511:0]       r_s;
  // Only feed-forward words that can reach a digest are kept
  logic [319:0]       r_x_lo;
  logic [63:0]        r_x_cd;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [255:0]       r_out_data;

  logic [3:0][127:0]  w_rk;
  logic [511:0]       w_load;
  logic [511:0]       w_aes;
  logic [511:0]       w_mix;
  logic [511:0]       w_next;
  logic [319:0]       w_ff_lo;
  logic [63:0]        w_ff_cd;
  logic [255:0]       w_digest;

  assign w_load = in_mode ? in_data : {256'b0, in_data[255:0]};

  always_comb begin
    w_rk = '0;
    for (int l = 0; l < 4; l++) begin
      if (r_mode) begin
        w_rk[l] = rc[128*(4*int'(r_step) + l) +: 128];
      end else if (l < 2) begin
        w_rk[l] = rc[128*(2*int'(r_step) + l) +: 128];
      end
    end
  end

  always_comb begin
    w_aes = '0;
    for (int l = 0; l < 4; l++) w_aes[128*l +: 128] = aes_step(r_s[128*l +: 128], w_rk[l]);
    if (!r_mode) w_aes[511:256] = '0;
    w_mix = '0;
    if (r_mode) begin
      for (int i = 0; i < 16; i++) w_mix[32*i +: 32] = w_aes[32*int'(Mix512Map[4*i +: 4]) +: 32];
    end else begin
      for (int i = 0; i < 8; i++) w_mix[32*i +: 32] = w_aes[32*int'(Mix256Map[3*i +: 3]) +: 32];
    end
    w_next = r_step[0] ? w_mix : w_aes;
  end

  always_comb begin
    w_ff_lo  = w_next[319:0] ^ r_x_lo;
    w_ff_cd  = w_next[447:384] ^ r_x_cd;
    w_digest = r_mode ? {w_ff_cd, w_ff_lo[319:256], w_ff_lo[255:192], w_ff_lo[127:64]}
                      : w_ff_lo[255:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_step      <= '0;
      r_mode      <= 1'b0;
      r_s         <= '0;
      r_x_lo      <= '0;
      r_x_cd      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_s        <= w_load;
            r_x_lo     <= w_load[319:0];
            r_x_cd     <= w_load[447:384];
            r_mode     <= in_mode;
            r_step     <= '0;
            r_state    <= StBusy;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StBusy: begin
          r_s    <= w_next;
          r_step <= r_step + 1'b1;
          if (r_step == LastStep) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_out_data  <= w_digest;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule
